sensor_frame_sync: RTL and testbench

Pixel-clock front stage of a sensor channel, directly upstream of the I2C sequencer's frame_sync input.
- Consumes the registered parallel sensor signals: vact, hact and pixel data.
- Frames the pixel stream, counting pixels, lines and frames.
- Emits sof/eof pulses and a frame_sync pulse delayed by a programmable number of lines.
- The frame_sync pulse is carried to the mclk domain by the channel's pulse synchronizer, which lives outside this block.

---
 rtl/sensor_frame_sync_pkg.sv | 15 +
 rtl/sensor_frame_sync_sat_counter.sv | 26 ++
 rtl/sensor_frame_sync.sv | 136 +++++++++++++
 tb/tb_sensor_frame_sync.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_frame_sync_pkg.sv
// Shared state encoding and default widths for the sensor frame-sync front stage.
package sensor_frame_sync_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 12;
  localparam int unsigned DEF_PIX_BITS   = 14;
  localparam int unsigned DEF_LINE_BITS  = 14;
  localparam int unsigned DEF_FRAME_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FRAME = 2'd2
  } state_t;

endpackage

// File: rtl/sensor_frame_sync_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins) and async reset.
module sat_counter
  import sensor_frame_sync_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_PIX_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sensor_frame_sync.sv
// Frames the registered sensor stream: pixel/line/frame counts, sof/eof and a
// frame_sync pulse issued after a programmable number of completed lines.
module sensor_frame_sync
  import sensor_frame_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PIX_BITS   = DEF_PIX_BITS,
  parameter int unsigned LINE_BITS  = DEF_LINE_BITS,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_err,
  input  logic                  vact_in,
  input  logic                  hact_in,
  input  logic [DATA_WIDTH-1:0] pxd_in,
  input  logic [LINE_BITS-1:0]  fsync_delay,
  output logic [DATA_WIDTH-1:0] pxd_out,
  output logic                  hact_out,
  output logic                  sof,
  output logic                  eof,
  output logic                  frame_sync,
  output logic [PIX_BITS-1:0]   pix_num,
  output logic [LINE_BITS-1:0]  line_num,
  output logic [FRAME_BITS-1:0] frame_num,
  output logic [PIX_BITS-1:0]   last_width,
  output logic [LINE_BITS-1:0]  last_height,
  output logic                  err_hact,
  output logic                  err_short
);

  localparam logic [PIX_BITS-1:0]  PIX_MAX  = '1;
  localparam logic [LINE_BITS-1:0] LINE_MAX = '1;

  state_t                 state, next_state;
  logic                   enter_frame, leave_frame;
  logic                   hact_gated, line_done, fire, err_hact_set;
  logic [PIX_BITS-1:0]    width_now, width_q;
  logic [LINE_BITS-1:0]   lines_next, delay_q;
  logic                   fired;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state plus per-cycle event decode; hact_out acts as the previous gated hact.
  always_comb begin
    next_state   = state;
    enter_frame  = 1'b0;
    leave_frame  = 1'b0;
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (!vact_in) next_state = ARMED;
        ARMED:   if (vact_in) begin
                   next_state  = FRAME;
                   enter_frame = 1'b1;
                 end
        FRAME:   if (!vact_in) begin
                   next_state  = ARMED;
                   leave_frame = 1'b1;
                 end
        default: next_state = IDLE;
      endcase
    end
    hact_gated   = hact_in && ((state == FRAME) || enter_frame);
    line_done    = en && (state == FRAME) && hact_out && !hact_in;
    width_now    = (pix_num == PIX_MAX) ? pix_num : pix_num + PIX_BITS'(1);
    lines_next   = (line_done && (line_num != LINE_MAX)) ? line_num + LINE_BITS'(1) : line_num;
    fire         = (enter_frame && (fsync_delay == '0)) ||
                   (line_done && !fired && (lines_next == delay_q));
    err_hact_set = hact_in && !vact_in && ((state == ARMED) || (state == FRAME));
  end

  sat_counter #(.WIDTH(PIX_BITS)) u_pix_cnt (
    .clk   (pclk),
    .rst   (rst),
    .clr   (hact_gated && !hact_out),
    .inc   (hact_gated && hact_out),
    .count (pix_num)
  );

  sat_counter #(.WIDTH(LINE_BITS)) u_line_cnt (
    .clk   (pclk),
    .rst   (rst),
    .clr   (enter_frame),
    .inc   (line_done),
    .count (line_num)
  );

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      pxd_out     <= '0;
      hact_out    <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      frame_sync  <= 1'b0;
      frame_num   <= '0;
      last_width  <= '0;
      last_height <= '0;
      err_hact    <= 1'b0;
      err_short   <= 1'b0;
      width_q     <= '0;
      delay_q     <= '0;
      fired       <= 1'b0;
    end else begin
      pxd_out    <= pxd_in;
      hact_out   <= hact_gated;
      sof        <= enter_frame;
      eof        <= leave_frame;
      frame_sync <= fire;
      if (enter_frame) begin
        delay_q <= fsync_delay;
        fired   <= (fsync_delay == '0);
        width_q <= '0;
      end else begin
        if (fire)      fired   <= 1'b1;
        if (line_done) width_q <= width_now;
      end
      // A line finishing in the eof cycle belongs to the frame being closed.
      if (leave_frame) begin
        frame_num   <= frame_num + FRAME_BITS'(1);
        last_height <= lines_next;
        last_width  <= line_done ? width_now : width_q;
      end
      if (err_hact_set) err_hact <= 1'b1;
      else if (clr_err) err_hact <= 1'b0;
      if (leave_frame && !fired && !fire) err_short <= 1'b1;
      else if (clr_err)                   err_short <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sensor_frame_sync.sv
// Randomized and directed bench for sensor_frame_sync against a frame-level reference model.
module tb_sensor_frame_sync;

  localparam int unsigned DW    = 12;
  localparam int unsigned PB    = 14;
  localparam int unsigned LB    = 14;
  localparam int unsigned FB    = 4;
  localparam int unsigned PMAX  = (1 << PB) - 1;
  localparam int unsigned LMAX  = (1 << LB) - 1;
  localparam int unsigned FMOD  = 1 << FB;

  logic          pclk, rst, en, clr_err, vact_in, hact_in;
  logic [DW-1:0] pxd_in, pxd_out;
  logic [LB-1:0] fsync_delay;
  logic          hact_out, sof, eof, frame_sync, err_hact, err_short;
  logic [PB-1:0] pix_num, last_width;
  logic [LB-1:0] line_num, last_height;
  logic [FB-1:0] frame_num;

  sensor_frame_sync dut (
    .pclk(pclk), .rst(rst), .en(en), .clr_err(clr_err),
    .vact_in(vact_in), .hact_in(hact_in), .pxd_in(pxd_in), .fsync_delay(fsync_delay),
    .pxd_out(pxd_out), .hact_out(hact_out), .sof(sof), .eof(eof), .frame_sync(frame_sync),
    .pix_num(pix_num), .line_num(line_num), .frame_num(frame_num),
    .last_width(last_width), .last_height(last_height),
    .err_hact(err_hact), .err_short(err_short)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;
  int obs_sof = 0, obs_eof = 0, obs_fs = 0;
  bit rand_mode = 1'b0;

  // Reference model: frame-level bookkeeping with unbounded counts, saturated on output.
  bit            m_armed, m_active, fs_done;
  int unsigned   run, dly;
  int unsigned   lines[$];
  logic [DW-1:0] e_pxd;
  bit            e_hout, e_sof, e_eof, e_fs, e_err_hact, e_err_short;
  int unsigned   e_pix, e_line, e_frame, e_lw, e_lh;

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_active = 0; fs_done = 0; run = 0; dly = 0; lines.delete();
    e_pxd = '0; e_hout = 0; e_sof = 0; e_eof = 0; e_fs = 0; e_err_hact = 0; e_err_short = 0;
    e_pix = 0; e_line = 0; e_frame = 0; e_lw = 0; e_lh = 0;
  endtask

  task automatic model_step();
    bit was_frame, armed_st, start, stop, gated, done, fire, viol;
    was_frame = m_active;
    armed_st  = m_armed && !m_active;
    start = en && armed_st && vact_in;
    stop  = en && was_frame && !vact_in;
    gated = hact_in && (was_frame || start);
    done  = en && was_frame && e_hout && !hact_in;
    viol  = hact_in && !vact_in && (was_frame || armed_st);
    fire  = 0;
    e_pxd = pxd_in;
    if (done) lines.push_back(run);
    if (gated) begin
      run   = e_hout ? run + 1 : 1;
      e_pix = sat(run - 1, PMAX);
    end
    if (start) begin
      lines.delete();
      dly     = fsync_delay;
      fs_done = (dly == 0);
      fire    = (dly == 0);
      e_line  = 0;
    end
    if (done) begin
      e_line = sat(lines.size(), LMAX);
      if (!fs_done && lines.size() == dly) begin
        fire = 1; fs_done = 1;
      end
    end
    if (stop) begin
      e_frame = (e_frame + 1) % FMOD;
      e_lh    = sat(lines.size(), LMAX);
      e_lw    = (lines.size() != 0) ? sat(lines[$], PMAX) : 0;
    end
    if (stop && !fs_done) e_err_short = 1;
    else if (clr_err)     e_err_short = 0;
    if (viol)             e_err_hact = 1;
    else if (clr_err)     e_err_hact = 0;
    e_sof = start; e_eof = stop; e_fs = fire; e_hout = gated;
    if (!en)                        begin m_armed = 0; m_active = 0; end
    else if (start)                 m_active = 1;
    else if (stop)                  m_active = 0;
    else if (!was_frame && !vact_in) m_armed = 1;
  endtask

  task automatic compare_all();
    check("pxd_out",     32'(pxd_out),     32'(e_pxd));
    check("hact_out",    32'(hact_out),    32'(e_hout));
    check("sof",         32'(sof),         32'(e_sof));
    check("eof",         32'(eof),         32'(e_eof));
    check("frame_sync",  32'(frame_sync),  32'(e_fs));
    check("pix_num",     32'(pix_num),     e_pix);
    check("line_num",    32'(line_num),    e_line);
    check("frame_num",   32'(frame_num),   e_frame);
    check("last_width",  32'(last_width),  e_lw);
    check("last_height", 32'(last_height), e_lh);
    check("err_hact",    32'(err_hact),    32'(e_err_hact));
    check("err_short",   32'(err_short),   32'(e_err_short));
    if (sof)        obs_sof++;
    if (eof)        obs_eof++;
    if (frame_sync) obs_fs++;
  endtask

  task automatic cyc(input logic v, input logic h);
    vact_in = v; hact_in = h; pxd_in = DW'($urandom);
    if (rand_mode) begin
      en      = ($urandom_range(0, 149) != 0);
      clr_err = ($urandom_range(0, 15) == 0);
    end
    @(posedge pclk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic send_frame(input int nl, input int w, input int hgap, input int tail, input int vgap);
    cyc(1'b1, 1'b0);
    for (int l = 0; l < nl; l++) begin
      repeat (w) cyc(1'b1, 1'b1);
      repeat ((l == nl - 1) ? tail : hgap) cyc(1'b1, 1'b0);
    end
    for (int g = 0; g < vgap; g++)
      cyc(1'b0, rand_mode ? logic'($urandom_range(0, 7) == 0) : 1'b0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge pclk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  int s0, f0, e0;

  initial begin
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; vact_in = 1'b0; hact_in = 1'b0;
    pxd_in = '0; fsync_delay = '0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1;
    compare_all();
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);

    // 4x6 frame, frame_sync after the second line
    fsync_delay = LB'(2);
    s0 = obs_sof; f0 = obs_fs; e0 = obs_eof;
    send_frame(4, 6, 2, 2, 3);
    check("t1_sof_cnt", 32'(obs_sof - s0), 32'd1);
    check("t1_fs_cnt",  32'(obs_fs - f0),  32'd1);
    check("t1_eof_cnt", 32'(obs_eof - e0), 32'd1);
    check("t1_lw", 32'(last_width),  32'd6);
    check("t1_lh", 32'(last_height), 32'd4);
    check("t1_fn", 32'(frame_num),   32'd1);

    // enable raised mid-frame: partial frame must be ignored
    en = 1'b0;
    s0 = obs_sof;
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1);
    en = 1'b1;
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    check("t2_no_sof", 32'(obs_sof - s0), 32'd0);
    send_frame(3, 5, 2, 1, 3);
    check("t2_fn", 32'(frame_num),   32'd2);
    check("t2_lw", 32'(last_width),  32'd5);
    check("t2_lh", 32'(last_height), 32'd3);

    // zero delay, then a frame too short for its delay
    fsync_delay = '0;
    f0 = obs_fs;
    send_frame(2, 4, 2, 1, 3);
    check("t3_fs0_cnt", 32'(obs_fs - f0), 32'd1);
    fsync_delay = LB'(5);
    f0 = obs_fs;
    send_frame(4, 6, 2, 0, 3);
    check("t3_fs5_cnt",  32'(obs_fs - f0), 32'd0);
    check("t3_short",    32'(err_short),   32'd1);
    check("t3_lh_sim",   32'(last_height), 32'd4);
    clr_err = 1'b1;
    cyc(1'b0, 1'b0);
    clr_err = 1'b0;
    check("t3_short_clr", 32'(err_short), 32'd0);

    // hact outside vact
    cyc(1'b0, 1'b1);
    check("t4_err_hact", 32'(err_hact), 32'd1);
    check("t4_hout",     32'(hact_out), 32'd0);
    cyc(1'b0, 1'b0);
    clr_err = 1'b1;
    cyc(1'b0, 1'b1);
    check("t4_set_wins", 32'(err_hact), 32'd1);
    cyc(1'b0, 1'b0);
    clr_err = 1'b0;
    check("t4_cleared", 32'(err_hact), 32'd0);

    // async reset mid-line, vact still high afterwards
    fsync_delay = LB'(2);
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b1);
    async_reset();
    s0 = obs_sof;
    repeat (2) cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    check("t5_no_sof", 32'(obs_sof - s0), 32'd0);
    repeat (2) cyc(1'b0, 1'b0);
    send_frame(2, 3, 1, 1, 2);
    check("t5_sof", 32'(obs_sof - s0), 32'd1);
    check("t5_fn",  32'(frame_num),    32'd1);

    // frame counter wrap and pixel saturation
    async_reset();
    repeat (2) cyc(1'b0, 1'b0);
    fsync_delay = LB'(1);
    repeat (16) send_frame(1, 2, 1, 1, 2);
    check("t6_wrap", 32'(frame_num), 32'd0);
    send_frame(1, 2, 1, 1, 2);
    check("t6_after_wrap", 32'(frame_num), 32'd1);
    cyc(1'b1, 1'b0);
    repeat (PMAX + 4) cyc(1'b1, 1'b1);
    check("t6_pix_sat", 32'(pix_num), 32'd16383);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("t6_lw_sat", 32'(last_width), 32'd16383);
    cyc(1'b0, 1'b0);

    // randomized frames with aborts, error clears and stray hact
    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      fsync_delay = LB'($urandom_range(0, 6));
      send_frame($urandom_range(0, 6), $urandom_range(1, 8), $urandom_range(1, 3),
                 $urandom_range(0, 2), $urandom_range(1, 4));
    end
    rand_mode = 1'b0;
    en = 1'b1; clr_err = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
